control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/control_unit_if.sv | 45 ++++
 rtl/control_unit_instr_decoder.sv | 36 +++
 rtl/control_unit.sv | 171 +++++++++++++++++
 tb/tb_control_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared encodings for the CPU control path: sequencer states, opcodes,
// ALU function codes, register-file FunSel codes, mux selects and the
// instruction classes produced by the decoder. No ports (package).
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC1   = 3'd3,
        ST_EXEC2   = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_NOT = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_BRA = 4'h8;
    localparam logic [3:0] OP_BNE = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_NOT_A  = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [1:0] ARF_SEL_PC = 2'b00;
    localparam logic [1:0] ARF_SEL_AR = 2'b01;
    localparam logic [3:0] ARF_REG_PC = 4'b0001;
    localparam logic [3:0] ARF_REG_AR = 4'b0010;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;
    localparam logic [1:0] MUX_ARFC = 2'b11;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LDI,
        CLS_ST,
        CLS_LD,
        CLS_BRA,
        CLS_BNE,
        CLS_HLT,
        CLS_NOP
    } instr_class_t;

    // Register index 0..3 (R1..R4) to one-hot RSel, R1 on bit 3.
    function automatic logic [3:0] rfOneHot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if
// Bundles the instruction/flag inputs and all datapath control outputs of
// the control unit.
//   master : control unit side (reads IROut/ALUOutFlag, drives controls)
//   slave  : datapath side (drives IROut/ALUOutFlag, reads controls)
interface control_unit_if;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic        Halted;
    logic [2:0]  State;

    modport master (
        input  IROut, ALUOutFlag,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
               ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, State
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
               ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, State
    );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// instr_decoder
// Maps the 4-bit opcode to an instruction class and an ALU function code.
//   opcode     : IR[15:12]
//   instrClass : instruction class (undefined opcodes -> CLS_NOP)
//   aluCode    : ALU_FunSel to use for ALU-class instructions
//   aluUnary   : ALU op takes only Rs (NOT)
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_t instrClass,
    output logic [3:0]   aluCode,
    output logic         aluUnary
);

    always_comb begin
        instrClass = CLS_NOP;
        aluCode    = ALU_PASS_A;
        aluUnary   = 1'b0;
        case (opcode)
            OP_AND: begin instrClass = CLS_ALU; aluCode = ALU_AND; end
            OP_OR:  begin instrClass = CLS_ALU; aluCode = ALU_OR;  end
            OP_NOT: begin instrClass = CLS_ALU; aluCode = ALU_NOT_A; aluUnary = 1'b1; end
            OP_ADD: begin instrClass = CLS_ALU; aluCode = ALU_ADD; end
            OP_SUB: begin instrClass = CLS_ALU; aluCode = ALU_SUB; end
            OP_LDI: instrClass = CLS_LDI;
            OP_ST:  instrClass = CLS_ST;
            OP_LD:  instrClass = CLS_LD;
            OP_BRA: instrClass = CLS_BRA;
            OP_BNE: instrClass = CLS_BNE;
            OP_HLT: instrClass = CLS_HLT;
            default: instrClass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Instruction sequencer for the 16-bit CPU. Fetches a 16-bit instruction as
// two byte reads, then drives the datapath for one or two execute cycles.
//   Clock : sole clock, rising edge
//   Reset : asynchronous active-low; forces INIT and idle outputs
//   bus   : control_unit_if.master (IROut/ALUOutFlag in, datapath controls out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// INIT    | clear PC
// FETCH_L | read mem[PC] into IR low byte, PC++
// FETCH_H | read mem[PC] into IR high byte, PC++
// EXEC1   | execute (ALU/LDI/BRA/BNE complete; ST/LD load AR)
// EXEC2   | memory access for ST/LD
// HALT    | idle forever until Reset
module control_unit
    import cpu_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    control_unit_if.master bus
);

    state_t       state;
    state_t       stateNext;
    logic         zFlag;
    instr_class_t instrClass;
    logic [3:0]   aluCode;
    logic         aluUnary;
    logic [1:0]   rd;
    logic [1:0]   rs;
    logic         unusedBits;

    assign rd = bus.IROut[11:10];
    assign rs = bus.IROut[9:8];

    // Immediate byte is routed by the datapath muxes; only Z is consumed here.
    assign unusedBits = ^{bus.IROut[7:0], bus.ALUOutFlag[2:0]};

    instr_decoder u_decoder (
        .opcode     (bus.IROut[15:12]),
        .instrClass (instrClass),
        .aluCode    (aluCode),
        .aluUnary   (aluUnary)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_INIT;
            zFlag <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == ST_EXEC1 && instrClass == CLS_ALU)
                zFlag <= bus.ALUOutFlag[3];
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_INIT:    stateNext = ST_FETCH_L;
            ST_FETCH_L: stateNext = ST_FETCH_H;
            ST_FETCH_H: stateNext = ST_EXEC1;
            ST_EXEC1: begin
                case (instrClass)
                    CLS_ST, CLS_LD: stateNext = ST_EXEC2;
                    CLS_HLT:        stateNext = ST_HALT;
                    default:        stateNext = ST_FETCH_L;
                endcase
            end
            ST_EXEC2:   stateNext = ST_FETCH_L;
            ST_HALT:    stateNext = ST_HALT;
            default:    stateNext = ST_INIT;
        endcase
    end

    always_comb begin
        bus.RF_OutASel  = 3'd0;
        bus.RF_OutBSel  = 3'd0;
        bus.RF_FunSel   = FUN_CLR;
        bus.RF_RSel     = 4'b0000;
        bus.RF_TSel     = 4'b0000;
        bus.ALU_FunSel  = ALU_PASS_A;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b00;
        bus.ARF_FunSel  = FUN_CLR;
        bus.ARF_RegSel  = 4'b0000;
        bus.IR_LH       = 1'b0;
        bus.IR_Enable   = 1'b0;
        bus.IR_Funsel   = FUN_CLR;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxASel     = MUX_ALU;
        bus.MuxBSel     = MUX_ALU;
        bus.MuxCSel     = 1'b0;
        // Gating on Reset keeps the INIT PC-clear (and any memory strobe)
        // off while reset is still held low.
        if (Reset) begin
            case (state)
                ST_INIT: begin
                    bus.ARF_RegSel = ARF_REG_PC;
                    bus.ARF_FunSel = FUN_CLR;
                end
                ST_FETCH_L, ST_FETCH_H: begin
                    bus.ARF_OutDSel = ARF_SEL_PC;
                    bus.Mem_CS      = 1'b0;
                    bus.IR_Enable   = 1'b1;
                    bus.IR_LH       = (state == ST_FETCH_H);
                    bus.IR_Funsel   = FUN_LOAD;
                    bus.ARF_RegSel  = ARF_REG_PC;
                    bus.ARF_FunSel  = FUN_INC;
                end
                ST_EXEC1: begin
                    case (instrClass)
                        CLS_ALU: begin
                            bus.RF_OutASel = aluUnary ? {1'b0, rs} : {1'b0, rd};
                            bus.RF_OutBSel = {1'b0, rs};
                            bus.MuxCSel    = 1'b0;
                            bus.ALU_FunSel = aluCode;
                            bus.MuxASel    = MUX_ALU;
                            bus.RF_RSel    = rfOneHot(rd);
                            bus.RF_FunSel  = FUN_LOAD;
                        end
                        CLS_LDI: begin
                            bus.MuxASel   = MUX_IMM;
                            bus.RF_RSel   = rfOneHot(rd);
                            bus.RF_FunSel = FUN_LOAD;
                        end
                        CLS_ST, CLS_LD: begin
                            bus.MuxBSel    = MUX_IMM;
                            bus.ARF_RegSel = ARF_REG_AR;
                            bus.ARF_FunSel = FUN_LOAD;
                        end
                        CLS_BRA: begin
                            bus.MuxBSel    = MUX_IMM;
                            bus.ARF_RegSel = ARF_REG_PC;
                            bus.ARF_FunSel = FUN_LOAD;
                        end
                        CLS_BNE: begin
                            if (!zFlag) begin
                                bus.MuxBSel    = MUX_IMM;
                                bus.ARF_RegSel = ARF_REG_PC;
                                bus.ARF_FunSel = FUN_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_EXEC2: begin
                    bus.ARF_OutDSel = ARF_SEL_AR;
                    bus.Mem_CS      = 1'b0;
                    if (instrClass == CLS_ST) begin
                        bus.RF_OutASel = {1'b0, rs};
                        bus.MuxCSel    = 1'b0;
                        bus.ALU_FunSel = ALU_PASS_A;
                        bus.Mem_WR     = 1'b1;
                    end else begin
                        bus.MuxASel   = MUX_MEM;
                        bus.RF_RSel   = rfOneHot(rd);
                        bus.RF_FunSel = FUN_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Halted = (state == ST_HALT);
    assign bus.State  = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Directed stimulus for control_unit; each cycle's hand-computed expected
// output vector is queued, and a monitor pops and compares on the falling
// edge (or on an explicit event for the asynchronous reset check).
module tb_control_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [2:0] state;
        logic       halted;
        logic [2:0] outA;
        logic [2:0] outB;
        logic [1:0] rfFun;
        logic [3:0] rfRSel;
        logic [3:0] rfTSel;
        logic [3:0] aluFun;
        logic [1:0] arfC;
        logic [1:0] arfD;
        logic [1:0] arfFun;
        logic [3:0] arfReg;
        logic       irLH;
        logic       irEn;
        logic [1:0] irFun;
        logic       memWR;
        logic       memCS;
        logic [1:0] muxA;
        logic [1:0] muxB;
        logic       muxC;
    } vec_t;

    typedef struct {
        vec_t  v;
        string nm;
    } exp_t;

    logic Clock;
    logic Reset;
    control_unit_if bus();

    control_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    exp_t sbQ[$];
    int   nTests = 0;
    int   nFail  = 0;
    event asyncChk;
    exp_t cur;
    vec_t act;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic vec_t vIdle(input logic [2:0] st);
        vec_t v;
        v = '0;
        v.memCS = 1'b1;
        v.state = st;
        return v;
    endfunction

    function automatic vec_t vInit();
        vec_t v;
        v = vIdle(ST_INIT);
        v.arfReg = 4'b0001;
        v.arfFun = 2'b00;
        return v;
    endfunction

    function automatic vec_t vFetch(input logic lh);
        vec_t v;
        v = vIdle(lh ? ST_FETCH_H : ST_FETCH_L);
        v.arfD   = ARF_SEL_PC;
        v.memCS  = 1'b0;
        v.irEn   = 1'b1;
        v.irLH   = lh;
        v.irFun  = 2'b01;
        v.arfReg = 4'b0001;
        v.arfFun = 2'b11;
        return v;
    endfunction

    function automatic vec_t vPcLoad();
        vec_t v;
        v = vIdle(ST_EXEC1);
        v.muxB   = 2'b10;
        v.arfReg = 4'b0001;
        v.arfFun = 2'b01;
        return v;
    endfunction

    function automatic vec_t vArLoad();
        vec_t v;
        v = vIdle(ST_EXEC1);
        v.muxB   = 2'b10;
        v.arfReg = 4'b0010;
        v.arfFun = 2'b01;
        return v;
    endfunction

    function automatic vec_t vLdi();
        vec_t v;
        v = vIdle(ST_EXEC1);
        v.muxA   = 2'b10;
        v.rfRSel = 4'b0010;
        v.rfFun  = 2'b01;
        return v;
    endfunction

    function automatic vec_t vAlu(input logic [2:0] a, input logic [2:0] b,
                                  input logic [3:0] fn, input logic [3:0] rsel);
        vec_t v;
        v = vIdle(ST_EXEC1);
        v.outA   = a;
        v.outB   = b;
        v.aluFun = fn;
        v.rfRSel = rsel;
        v.rfFun  = 2'b01;
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.state  = bus.State;
        v.halted = bus.Halted;
        v.outA   = bus.RF_OutASel;
        v.outB   = bus.RF_OutBSel;
        v.rfFun  = bus.RF_FunSel;
        v.rfRSel = bus.RF_RSel;
        v.rfTSel = bus.RF_TSel;
        v.aluFun = bus.ALU_FunSel;
        v.arfC   = bus.ARF_OutCSel;
        v.arfD   = bus.ARF_OutDSel;
        v.arfFun = bus.ARF_FunSel;
        v.arfReg = bus.ARF_RegSel;
        v.irLH   = bus.IR_LH;
        v.irEn   = bus.IR_Enable;
        v.irFun  = bus.IR_Funsel;
        v.memWR  = bus.Mem_WR;
        v.memCS  = bus.Mem_CS;
        v.muxA   = bus.MuxASel;
        v.muxB   = bus.MuxBSel;
        v.muxC   = bus.MuxCSel;
        return v;
    endfunction

    function automatic void push(input vec_t v, input string nm);
        exp_t x;
        x.v  = v;
        x.nm = nm;
        sbQ.push_back(x);
    endfunction

    task automatic cyc(input logic rst, input logic [15:0] ir, input logic [3:0] flg,
                       input vec_t e, input string nm);
        @(posedge Clock);
        #1;
        Reset          = rst;
        bus.IROut      = ir;
        bus.ALUOutFlag = flg;
        push(e, nm);
    endtask

    task automatic fetch2(input logic [15:0] ir);
        cyc(1'b1, ir, 4'h0, vFetch(1'b0), "fetch_l");
        cyc(1'b1, ir, 4'h0, vFetch(1'b1), "fetch_h");
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge Clock or asyncChk);
            if (sbQ.size() > 0) begin
                cur = sbQ.pop_front();
                act = sample();
                nTests++;
                if (act !== cur.v) begin
                    nFail++;
                    $display("FAIL %s: state got %0d want %0d, vector got %h want %h",
                             cur.nm, act.state, cur.v.state, act, cur.v);
                end
            end
        end
    end

    // Stimulus
    initial begin
        vec_t e;
        Reset          = 1'b0;
        bus.IROut      = 16'h0000;
        bus.ALUOutFlag = 4'h0;

        cyc(1'b0, 16'h0000, 4'h0, vIdle(ST_INIT), "rst_low0");
        cyc(1'b0, 16'hF000, 4'hF, vIdle(ST_INIT), "rst_low1");
        cyc(1'b1, 16'h0000, 4'h0, vInit(), "init");

        fetch2(16'h5A3C);
        cyc(1'b1, 16'h5A3C, 4'h0, vLdi(), "ldi_exec1");

        fetch2(16'h3100);
        cyc(1'b1, 16'h3100, 4'h0, vAlu(3'd0, 3'd1, ALU_ADD, 4'b1000), "add_exec1");

        fetch2(16'h9040);
        cyc(1'b1, 16'h9040, 4'h0, vPcLoad(), "bne_z0_taken");

        fetch2(16'h4000);
        cyc(1'b1, 16'h4000, 4'b1000, vAlu(3'd0, 3'd0, ALU_SUB, 4'b1000), "sub_exec1");

        fetch2(16'h9040);
        cyc(1'b1, 16'h9040, 4'h0, vIdle(ST_EXEC1), "bne_z1_not_taken");

        fetch2(16'h5A3C);
        cyc(1'b1, 16'h5A3C, 4'h0, vLdi(), "ldi_keeps_z");

        fetch2(16'h9040);
        cyc(1'b1, 16'h9040, 4'h0, vIdle(ST_EXEC1), "bne_after_ldi");

        fetch2(16'h2E00);
        cyc(1'b1, 16'h2E00, 4'h0, vAlu(3'd2, 3'd2, ALU_NOT_A, 4'b0001), "not_exec1");

        fetch2(16'h9040);
        cyc(1'b1, 16'h9040, 4'h0, vPcLoad(), "bne_after_not");

        fetch2(16'h8055);
        cyc(1'b1, 16'h8055, 4'h0, vPcLoad(), "bra_exec1");

        fetch2(16'hC123);
        cyc(1'b1, 16'hC123, 4'h0, vIdle(ST_EXEC1), "nop_exec1");

        fetch2(16'h7444);
        cyc(1'b1, 16'h7444, 4'h0, vArLoad(), "ld_exec1");
        e = vIdle(ST_EXEC2);
        e.arfD   = ARF_SEL_AR;
        e.memCS  = 1'b0;
        e.muxA   = 2'b01;
        e.rfRSel = 4'b0100;
        e.rfFun  = 2'b01;
        cyc(1'b1, 16'h7444, 4'h0, e, "ld_exec2");

        fetch2(16'h6180);
        cyc(1'b1, 16'h6180, 4'h0, vArLoad(), "st_exec1");
        e = vIdle(ST_EXEC2);
        e.arfD   = ARF_SEL_AR;
        e.outA   = 3'd1;
        e.aluFun = ALU_PASS_A;
        e.memCS  = 1'b0;
        e.memWR  = 1'b1;
        cyc(1'b1, 16'h6180, 4'h0, e, "st_exec2");

        fetch2(16'h6180);
        cyc(1'b1, 16'h6180, 4'h0, vArLoad(), "st2_exec1");
        cyc(1'b1, 16'h6180, 4'h0, e, "st2_exec2");
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        push(vIdle(ST_INIT), "rst_mid_st_exec2");
        -> asyncChk;
        cyc(1'b1, 16'h6180, 4'h0, vInit(), "init_after_rst");

        fetch2(16'hF000);
        cyc(1'b1, 16'hF000, 4'h0, vIdle(ST_EXEC1), "hlt_exec1");
        e = vIdle(ST_HALT);
        e.halted = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 16'h6180, 4'hF, e, "halt_idle");

        repeat (3) @(negedge Clock);
        nTests++;
        if (sbQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d expectations left, want 0", sbQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
